// File: rtl/rv32_mod_load_store_unit_pkg.sv
// Shared types for the load/store unit.
//  lsu_state_t    : FSM states of the LSU (IDLE, BUS, RESP)
//  lsu_err_t      : completion code returned with lsu_done; the same encoding
//                   is used by writeback when the source is WB_SOURCE_LSU
//  LSU_W_*        : access width field of lsu_ram_req[1:0]
//  lsu_bad_access : misaligned-or-illegal check on width and addr[1:0]
package rv32_mod_load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        LSU_ERR_OK      = 2'd0,
        LSU_ERR_ALIGN   = 2'd1,
        LSU_ERR_BUS     = 2'd2,
        LSU_ERR_TIMEOUT = 2'd3
    } lsu_err_t;

    localparam logic [1:0] LSU_W_B = 2'b00;
    localparam logic [1:0] LSU_W_H = 2'b01;
    localparam logic [1:0] LSU_W_W = 2'b10;

    // Writeback mux select that carries lsu_err_t/lsu_rdata back to the regfile.
    localparam logic [1:0] WB_SOURCE_LSU = 2'd2;

    // True when the access must be rejected without touching the bus.
    function automatic logic lsu_bad_access(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            LSU_W_B: return 1'b0;
            LSU_W_H: return lo[0];
            LSU_W_W: return (lo != 2'b00);
            default: return 1'b1;   // width 11 is illegal
        endcase
    endfunction

endpackage

// File: rtl/rv32_mod_load_store_unit_if.sv
// Pipeline request/response and data-memory bus signals of the LSU.
//  slave  : the LSU view (takes requests, drives the memory bus)
//  master : the pipeline + memory view (issues requests, answers the bus)
interface rv32_mod_load_store_unit_if;
    // pipeline side
    logic        lsu_valid;
    logic [3:0]  lsu_ram_req;
    logic        lsu_ram_wr;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [1:0]  lsu_err;
    logic [31:0] lsu_rdata;
    // data-memory bus
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic        dmem_err;
    logic [31:0] dmem_rdata;

    modport slave (
        input  lsu_valid, lsu_ram_req, lsu_ram_wr, lsu_addr, lsu_wdata,
        output lsu_busy, lsu_done, lsu_err, lsu_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_err, dmem_rdata
    );

    modport master (
        output lsu_valid, lsu_ram_req, lsu_ram_wr, lsu_addr, lsu_wdata,
        input  lsu_busy, lsu_done, lsu_err, lsu_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_err, dmem_rdata
    );
endinterface

// File: rtl/rv32_mod_load_store_unit_align.sv
// Combinational data alignment for the LSU.
//  store side: st_width_i, st_addr_lo_i, st_data_i -> st_be_o, st_wdata_o
//              (byte/half data replicated across all lanes)
//  load side : ld_width_i, ld_addr_lo_i, ld_unsigned_i, ld_bus_data_i -> ld_data_o
//              (byte/half picked by address, sign- or zero-extended)
module rv32_mod_lsu_align
    import rv32_mod_load_store_unit_pkg::*;
(
    input  logic [1:0]  st_width_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_width_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_bus_data_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be_o    = 4'hF;
        st_wdata_o = st_data_i;
        case (st_width_i)
            LSU_W_B: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            LSU_W_H: begin
                st_be_o    = st_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;  // word (illegal widths never reach the bus)
        endcase
    end

    always_comb begin
        ld_byte = ld_bus_data_i[7:0];
        case (ld_addr_lo_i)
            2'd1:    ld_byte = ld_bus_data_i[15:8];
            2'd2:    ld_byte = ld_bus_data_i[23:16];
            2'd3:    ld_byte = ld_bus_data_i[31:24];
            default: ;
        endcase
        ld_half = ld_addr_lo_i[1] ? ld_bus_data_i[31:16] : ld_bus_data_i[15:0];

        ld_data_o = ld_bus_data_i;
        case (ld_width_i)
            LSU_W_B: ld_data_o = ld_unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            LSU_W_H: ld_data_o = ld_unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/rv32_mod_load_store_unit.sv
// Load/store unit: one outstanding req/ack transaction on the data bus.
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  lsu_bus    : slave modport of rv32_mod_load_store_unit_if
//               pipeline request (valid/ram_req/ram_wr/addr/wdata) in,
//               busy/done/err/rdata out; dmem_* bus master.
// Parameters:
//  TIMEOUT_CYCLES : BUS cycles before abort with LSU_ERR_TIMEOUT, 0 disables
//  CNT_WIDTH      : timeout counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
module rv32_mod_load_store_unit
    import rv32_mod_load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input logic                          clk,
    input logic                          rst_n,
    rv32_mod_load_store_unit_if.slave    lsu_bus
);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_t           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    lsu_err_t             err_q;
    logic [31:0]          rdata_q;
    logic                 we_q;
    logic [31:0]          addr_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    // load-extract controls kept for the response cycle
    logic [1:0]           ld_width_q;
    logic [1:0]           ld_lo_q;
    logic                 ld_uns_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        accept;
    logic        bad_access;
    logic        unused_req_bit;

    // bit 3 of the request field carries nothing for the LSU
    assign unused_req_bit = lsu_bus.lsu_ram_req[3];

    rv32_mod_lsu_align u_align (
        .st_width_i    (lsu_bus.lsu_ram_req[1:0]),
        .st_addr_lo_i  (lsu_bus.lsu_addr[1:0]),
        .st_data_i     (lsu_bus.lsu_wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .ld_width_i    (ld_width_q),
        .ld_addr_lo_i  (ld_lo_q),
        .ld_unsigned_i (ld_uns_q),
        .ld_bus_data_i (lsu_bus.dmem_rdata),
        .ld_data_o     (ld_data)
    );

    // busy only while a bus cycle is open, so RESP can accept back-to-back
    assign lsu_bus.lsu_busy   = (state_q == ST_BUS);
    assign lsu_bus.dmem_req   = (state_q == ST_BUS);
    assign lsu_bus.lsu_done   = (state_q == ST_RESP);
    assign lsu_bus.lsu_err    = err_q;
    assign lsu_bus.lsu_rdata  = rdata_q;
    assign lsu_bus.dmem_we    = we_q;
    assign lsu_bus.dmem_addr  = addr_q;
    assign lsu_bus.dmem_be    = be_q;
    assign lsu_bus.dmem_wdata = wdata_q;

    assign accept     = lsu_bus.lsu_valid && (state_q != ST_BUS);
    assign bad_access = lsu_bad_access(lsu_bus.lsu_ram_req[1:0], lsu_bus.lsu_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= LSU_ERR_OK;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            ld_width_q <= '0;
            ld_lo_q    <= '0;
            ld_uns_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_BUS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // bus error outranks ack, ack outranks timeout
                    if (lsu_bus.dmem_err) begin
                        state_q <= ST_RESP;
                        err_q   <= LSU_ERR_BUS;
                        rdata_q <= '0;
                    end else if (lsu_bus.dmem_ack) begin
                        state_q <= ST_RESP;
                        err_q   <= LSU_ERR_OK;
                        rdata_q <= we_q ? 32'h0 : ld_data;
                    end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST)) begin
                        state_q <= ST_RESP;
                        err_q   <= LSU_ERR_TIMEOUT;
                        rdata_q <= '0;
                    end
                end
                default: begin  // IDLE and RESP both take new requests
                    if (accept) begin
                        if (bad_access) begin
                            state_q <= ST_RESP;
                            err_q   <= LSU_ERR_ALIGN;
                            rdata_q <= '0;
                        end else begin
                            state_q    <= ST_BUS;
                            cnt_q      <= '0;
                            we_q       <= lsu_bus.lsu_ram_wr;
                            addr_q     <= {lsu_bus.lsu_addr[31:2], 2'b00};
                            be_q       <= st_be;
                            wdata_q    <= st_wdata;
                            ld_width_q <= lsu_bus.lsu_ram_req[1:0];
                            ld_lo_q    <= lsu_bus.lsu_addr[1:0];
                            ld_uns_q   <= lsu_bus.lsu_ram_req[2];
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
module tb_rv32_mod_load_store_unit;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    rv32_mod_load_store_unit_if bif();

    rv32_mod_load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lsu_bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] brd;   // data the memory returns
        int          dly;   // cycles of dmem_req before the response
        logic        ack;
        logic        berr;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [1:0]  eerr;
        logic [31:0] erd;
        int          lat;   // accept edge to lsu_done, in cycles
    } vec_t;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [3:0] req, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] brd, input int dly,
                                input logic ack, input logic berr, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [1:0] eerr,
                                input logic [31:0] erd, input int lat);
        vec_t v;
        v.req = req; v.wr = wr; v.addr = addr; v.wd = wd; v.brd = brd; v.dly = dly;
        v.ack = ack; v.berr = berr; v.be = be; v.ewd = ewd; v.eerr = eerr; v.erd = erd;
        v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] req, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd);
        bif.lsu_valid   = 1'b1;
        bif.lsu_ram_req = req;
        bif.lsu_ram_wr  = wr;
        bif.lsu_addr    = addr;
        bif.lsu_wdata   = wd;
    endtask

    task automatic push_exp(input logic [1:0] err, input logic [31:0] rd, input int lat);
        exp_t e;
        e.err = err; e.rdata = rd; e.lat = lat;
        sb.push_back(e);
    endtask

    // Called at a negedge; t0 is cyc sampled at the first negedge after accept.
    task automatic wait_done(input int t0, input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (!bif.lsu_done && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!bif.lsu_done) begin
            n_tests++; n_fail++;
            $display("FAIL %s_done: no lsu_done within 30 cycles", tag);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_sb: lsu_done with nothing expected", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_err"}, 32'(bif.lsu_err), 32'(e.err));
        chk({tag, "_rdata"}, bif.lsu_rdata, e.rdata);
        chk({tag, "_lat"}, 32'(cyc - t0 + 1), 32'(e.lat));
    endtask

    task automatic run(input vec_t v, input int idx);
        int    t0;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive_req(v.req, v.wr, v.addr, v.wd);
        bif.dmem_rdata = v.brd;
        push_exp(v.eerr, v.erd, v.lat);
        @(negedge clk);
        bif.lsu_valid = 1'b0;
        t0 = cyc;
        if (v.eerr == 2'd1) begin
            chk({tag, "_noreq"}, 32'(bif.dmem_req), 32'd0);
        end else begin
            chk({tag, "_req"}, 32'(bif.dmem_req), 32'd1);
            chk({tag, "_we"}, 32'(bif.dmem_we), 32'(v.wr));
            chk({tag, "_addr"}, bif.dmem_addr, {v.addr[31:2], 2'b00});
            if (v.wr) begin
                chk({tag, "_be"}, 32'(bif.dmem_be), 32'(v.be));
                chk({tag, "_wdata"}, bif.dmem_wdata, v.ewd);
            end
            repeat (v.dly) @(negedge clk);
            chk({tag, "_addr_hold"}, bif.dmem_addr, {v.addr[31:2], 2'b00});
            bif.dmem_ack = v.ack;
            bif.dmem_err = v.berr;
            @(negedge clk);
            bif.dmem_ack = 1'b0;
            bif.dmem_err = 1'b0;
        end
        wait_done(t0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int dones;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0;
        bif.lsu_valid = 1'b0; bif.lsu_ram_req = '0; bif.lsu_ram_wr = 1'b0;
        bif.lsu_addr = '0; bif.lsu_wdata = '0;
        bif.dmem_ack = 1'b0; bif.dmem_err = 1'b0; bif.dmem_rdata = '0;

        //                req     wr addr       wdata        bus rdata    dly ack err be     exp wdata    err  exp rdata   lat
        vecs.push_back(mk(4'b0010, 0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1, 0, 4'hF,  32'h0,        2'd0, 32'hDEADBEEF, 3));
        vecs.push_back(mk(4'b0000, 0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'hFFFFFF80, 2));
        vecs.push_back(mk(4'b0100, 0, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'h00000080, 2));
        vecs.push_back(mk(4'b0001, 1, 32'h102, 32'h1234ABCD, 32'h55555555, 0, 1, 0, 4'hC,  32'hABCDABCD, 2'd0, 32'h0,        2));
        vecs.push_back(mk(4'b0001, 0, 32'h101, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,        2'd1, 32'h0,        1));
        vecs.push_back(mk(4'b0011, 0, 32'h200, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,        2'd1, 32'h0,        1));
        vecs.push_back(mk(4'b0000, 1, 32'h201, 32'h1122335A, 32'h0,        0, 1, 0, 4'h2,  32'h5A5A5A5A, 2'd0, 32'h0,        2));
        vecs.push_back(mk(4'b0101, 0, 32'h102, 32'h0,        32'h80017FFF, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'h00008001, 2));
        vecs.push_back(mk(4'b0001, 0, 32'h100, 32'h0,        32'h12348001, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'hFFFF8001, 2));
        vecs.push_back(mk(4'b0010, 1, 32'h012, 32'h0,        32'h0,        0, 0, 0, 4'h0,  32'h0,        2'd1, 32'h0,        1));
        vecs.push_back(mk(4'b0010, 1, 32'h300, 32'hCAFEF00D, 32'h0,        2, 1, 0, 4'hF,  32'hCAFEF00D, 2'd0, 32'h0,        4));
        vecs.push_back(mk(4'b0010, 0, 32'h104, 32'h0,        32'hFFFFFFFF, 0, 0, 1, 4'h0,  32'h0,        2'd2, 32'h0,        2));
        vecs.push_back(mk(4'b0010, 0, 32'h108, 32'h0,        32'hFFFFFFFF, 1, 1, 1, 4'h0,  32'h0,        2'd2, 32'h0,        3));
        vecs.push_back(mk(4'b0010, 0, 32'h10C, 32'h0,        32'hFFFFFFFF, 0, 0, 0, 4'h0,  32'h0,        2'd3, 32'h0,        TO + 1));
        vecs.push_back(mk(4'b1010, 0, 32'h110, 32'h0,        32'h0BADF00D, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'h0BADF00D, 2));
        vecs.push_back(mk(4'b0000, 0, 32'h102, 32'h0,        32'h007F0000, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'h0000007F, 2));
        vecs.push_back(mk(4'b0100, 0, 32'h101, 32'h0,        32'h0000FF00, 0, 1, 0, 4'h0,  32'h0,        2'd0, 32'h000000FF, 2));
        vecs.push_back(mk(4'b0001, 1, 32'h100, 32'hFFFF8765, 32'h0,        0, 1, 0, 4'h3,  32'h87658765, 2'd0, 32'h0,        2));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bif.lsu_busy), 32'd0);
        chk("rst_done", 32'(bif.lsu_done), 32'd0);
        chk("rst_req", 32'(bif.dmem_req), 32'd0);
        chk("rst_err", 32'(bif.lsu_err), 32'd0);
        chk("rst_rdata", bif.lsu_rdata, 32'd0);
        chk("rst_bus", {bif.dmem_addr[27:0], bif.dmem_be}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i], i);

        // load data is held after its completion
        run(mk(4'b0010, 0, 32'h120, 32'h0, 32'h13579BDF, 0, 1, 0, 4'h0, 32'h0, 2'd0, 32'h13579BDF, 2), 100);
        @(negedge clk);
        chk("hold_done", 32'(bif.lsu_done), 32'd0);
        chk("hold_rdata", bif.lsu_rdata, 32'h13579BDF);

        // back-to-back: new accept during the RESP cycle
        drive_req(4'b0010, 1'b0, 32'h400, 32'h0);
        bif.dmem_rdata = 32'hA5A5A5A5;
        push_exp(2'd0, 32'hA5A5A5A5, 2);
        @(negedge clk);
        bif.lsu_valid = 1'b0;
        t0 = cyc;
        bif.dmem_ack = 1'b1;
        @(negedge clk);
        bif.dmem_ack = 1'b0;
        wait_done(t0, "b2b_first");
        drive_req(4'b0010, 1'b0, 32'h404, 32'h0);
        push_exp(2'd0, 32'h5A5A5A5A, 2);
        @(negedge clk);
        bif.lsu_valid = 1'b0;
        t0 = cyc;
        chk("b2b_req", 32'(bif.dmem_req), 32'd1);
        chk("b2b_addr", bif.dmem_addr, 32'h404);
        chk("b2b_nodone", 32'(bif.lsu_done), 32'd0);
        bif.dmem_rdata = 32'h5A5A5A5A;
        bif.dmem_ack = 1'b1;
        @(negedge clk);
        bif.dmem_ack = 1'b0;
        wait_done(t0, "b2b_second");

        // reset in the middle of a bus cycle, then a stale ack
        @(negedge clk);
        drive_req(4'b0010, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        bif.lsu_valid = 1'b0;
        chk("mid_req_before", 32'(bif.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_drop", 32'(bif.dmem_req), 32'd0);
        chk("mid_busy_drop", 32'(bif.lsu_busy), 32'd0);
        bif.dmem_ack = 1'b1;
        bif.dmem_rdata = 32'h77777777;
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.lsu_done) dones++;
        end
        bif.dmem_ack = 1'b0;
        chk("mid_no_done", 32'(dones), 32'd0);
        chk("mid_rdata", bif.lsu_rdata, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
